seq_stage_controller: RTL

//  Multi-cycle sequencer for the Y86-64 SEQ datapath (fetch/decode/execute/memory/writeback/pc_update).

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/seq_stage_controller_mem_wait_timer.sv | 31 +++
 rtl/seq_stage_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, sequencer states
// and the per-icode stage-usage helpers used by the SEQ controller.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_PCUPD,
    ST_HALT
  } stage_e;

  function automatic logic uses_mem(input logic [3:0] icode);
    return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction

  // nop, rmmovq and jxx touch no register, so they skip WRITEBACK.
  function automatic logic needs_wb(input logic [3:0] icode);
    return icode inside {IRRMOVQ, IIRMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction

endpackage

// File: rtl/seq_stage_controller_mem_wait_timer.sv
// Watchdog for the MEMORY stage: counts wait cycles and flags the last
// permitted one. A timeout of 0 disables the watchdog entirely.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [W-1:0] count;

  // Saturates so a disabled watchdog never wraps back into a false match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: one-hot stage enables,
// data-memory handshake with watchdog, processor status and activity counters.
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             step_mode_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             mem_ready_i,
  input  logic             dmem_error_i,
  output logic             f_en_o,
  output logic             d_en_o,
  output logic             e_en_o,
  output logic             m_en_o,
  output logic             w_en_o,
  output logic             pc_en_o,
  output logic             mem_req_o,
  output logic             busy_o,
  output logic [2:0]       stat_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  stage_e     state;
  stage_e     next_state;
  logic [2:0] next_stat;
  logic [3:0] icode_q;
  logic       mem_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .clear  (!m_en_o),
    .enable (m_en_o),
    .expired(mem_expired)
  );

  // Fault priority inside a stage: address faults beat everything else.
  always_comb begin
    next_state = state;
    next_stat  = stat_o;
    case (state)
      ST_IDLE: begin
        if (run_i) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_error_i) begin
          next_state = ST_HALT;
          next_stat  = SADR;
        end else if (!instr_valid_i) begin
          next_state = ST_HALT;
          next_stat  = SINS;
        end else if (icode_i == IHALT) begin
          next_state = ST_HALT;
          next_stat  = SHLT;
        end else begin
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: next_state = ST_EXECUTE;
      ST_EXECUTE: begin
        if (uses_mem(icode_q))      next_state = ST_MEMORY;
        else if (needs_wb(icode_q)) next_state = ST_WRITEBACK;
        else                        next_state = ST_PCUPD;
      end
      ST_MEMORY: begin
        if (dmem_error_i) begin
          next_state = ST_HALT;
          next_stat  = SADR;
        end else if (mem_ready_i) begin
          next_state = needs_wb(icode_q) ? ST_WRITEBACK : ST_PCUPD;
        end else if (mem_expired) begin
          next_state = ST_HALT;
          next_stat  = SADR;
        end
      end
      ST_WRITEBACK: next_state = ST_PCUPD;
      ST_PCUPD:     next_state = step_mode_i ? ST_IDLE : ST_FETCH;
      ST_HALT:      next_state = ST_HALT;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      stat_o    <= SAOK;
      icode_q   <= INOP;
      f_en_o    <= 1'b0;
      d_en_o    <= 1'b0;
      e_en_o    <= 1'b0;
      m_en_o    <= 1'b0;
      w_en_o    <= 1'b0;
      pc_en_o   <= 1'b0;
      mem_req_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= next_state;
      stat_o    <= next_stat;
      if (state == ST_FETCH) icode_q <= icode_i;
      f_en_o    <= (next_state == ST_FETCH);
      d_en_o    <= (next_state == ST_DECODE);
      e_en_o    <= (next_state == ST_EXECUTE);
      m_en_o    <= (next_state == ST_MEMORY);
      w_en_o    <= (next_state == ST_WRITEBACK);
      pc_en_o   <= (next_state == ST_PCUPD);
      mem_req_o <= (next_state == ST_MEMORY);
      busy_o    <= (next_state != ST_IDLE) && (next_state != ST_HALT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt_o <= '0;
    end else if (busy_o && cycle_cnt_o != '1) begin
      cycle_cnt_o <= cycle_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retired_cnt_o <= '0;
    end else if (pc_en_o && retired_cnt_o != '1) begin
      retired_cnt_o <= retired_cnt_o + 1'b1;
    end
  end

endmodule
